uart_rx: RTL and testbench

Serial receiver for the chiptune datapath. It recovers 8N1 bytes from the asynchronous host RX line and presents each byte as a one-cycle `valid` strobe with parallel data to the downstream register loader. It also drives the activity-stretched `link` status LED. It sits directly downstream of the top-level `rx` pin, ahead of the tone/register logic that produces `pwm` and `dac`.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with byte strobe, framing error strobe and link activity LED
// Mid-bit sampling from a single down-counter; link LED held for LINKTIME clocks after each byte.
module uart_rx #(
  parameter int OSCRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int LINKTIME = 1_200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       link
);

  localparam int DIV  = OSCRATE / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int LW   = $clog2(LINKTIME + 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx: OSCRATE/BAUDRATE must be at least 4");
    end
  endgenerate

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  logic          rx_m;
  logic          rx_s;
  logic [1:0]    sync_ok;
  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [LW-1:0] link_cnt;
  logic          sample;

  assign sample = (bit_cnt == '0);

  // sync_ok marks when rx_s reflects the real pin rather than the reset value of the
  // synchronizer, so a line held low through reset is not mistaken for idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      sync_ok <= 2'b00;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (state == START || state == DATA || state == STOP) begin
        bit_cnt <= sample ? CW'(DIV - 1) : bit_cnt - 1'b1;
      end
      case (state)
        WAIT_IDLE: begin
          if (sync_ok[1] && rx_s) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            bit_cnt <= CW'(HALF - 1);
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // link is registered off the counter so it rises the cycle after valid and
  // stays high for exactly LINKTIME cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_cnt <= '0;
      link     <= 1'b0;
    end else if (valid) begin
      link_cnt <= LW'(LINKTIME - 1);
      link     <= 1'b1;
    end else begin
      link <= (link_cnt != '0);
      if (link_cnt != '0) link_cnt <= link_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at DIV=100, HALF=50, LINKTIME=3000
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       link;

  uart_rx #(.OSCRATE(100_000), .BAUDRATE(1000), .LINKTIME(3000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .link(link)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int link_hi  = 0;
  int link_rise = -1;
  int link_last = -1;
  int start_cyc;
  logic link_prev = 1'b0;
  logic [7:0] vq[$];
  int         cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(data);
      cq.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (valid && frame_err) both_cnt++;
    if (link) begin
      link_hi++;
      link_last = cyc;
      if (!link_prev) link_rise = cyc;
    end
    link_prev = link;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    wait_clk(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(bit_t);
    end
    rx = stop_bit;
    wait_clk(bit_t);
  endtask

  task automatic clear_obs();
    vq.delete();
    cq.delete();
    fe_cnt = 0;
  endtask

  task automatic check_one(input string tag, input logic [7:0] exp);
    check_eq({tag, "_count"}, vq.size(), 1);
    if (vq.size() >= 1) check_eq({tag, "_data"}, vq[0], exp);
    check_eq({tag, "_ferr"}, fe_cnt, 0);
  endtask

  initial begin
    wait_clk(5);
    check_eq("rst_data", data, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_link", link, 0);
    rst = 1'b0;
    wait_clk(200);

    // single byte and its latency: pin edge + 2 sync + 50 + 9*100 + 1 = 953
    clear_obs();
    send_frame(8'h55, 100, 1'b1);
    wait_clk(100);
    check_one("single", 8'h55);
    if (cq.size() >= 1) check_eq("single_latency", cq[0] - start_cyc, 953);

    // back-to-back frames, strobes one frame (1000 clocks) apart
    clear_obs();
    send_frame(8'hA3, 100, 1'b1);
    send_frame(8'h0F, 100, 1'b1);
    wait_clk(100);
    check_eq("b2b_count", vq.size(), 2);
    if (vq.size() == 2) begin
      check_eq("b2b_data0", vq[0], 8'hA3);
      check_eq("b2b_data1", vq[1], 8'h0F);
      check_eq("b2b_gap", cq[1] - cq[0], 1000);
    end

    // glitch shorter than half a bit
    clear_obs();
    rx = 1'b0;
    wait_clk(30);
    rx = 1'b1;
    wait_clk(200);
    check_eq("glitch_valid", vq.size(), 0);
    check_eq("glitch_ferr", fe_cnt, 0);
    send_frame(8'h3C, 100, 1'b1);
    wait_clk(100);
    check_one("after_glitch", 8'h3C);

    // framing error followed by a long break
    clear_obs();
    send_frame(8'hFF, 100, 1'b0);
    check_eq("ferr_count", fe_cnt, 1);
    check_eq("ferr_valid", vq.size(), 0);
    check_eq("ferr_data_kept", data, 8'h3C);
    wait_clk(5000);
    check_eq("break_ferr", fe_cnt, 1);
    check_eq("break_valid", vq.size(), 0);
    rx = 1'b1;
    wait_clk(50);
    clear_obs();
    send_frame(8'h81, 100, 1'b1);
    wait_clk(100);
    check_one("after_break", 8'h81);

    // reset during data bit 4 of 0xC6 with the line held low
    clear_obs();
    rx = 1'b0;
    wait_clk(100);
    rx = 1'b0; wait_clk(100);
    rx = 1'b1; wait_clk(100);
    rx = 1'b1; wait_clk(100);
    rx = 1'b0; wait_clk(100);
    rx = 1'b0; wait_clk(40);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    check_eq("midrst_data", data, 0);
    check_eq("midrst_valid", valid, 0);
    check_eq("midrst_ferr", frame_err, 0);
    check_eq("midrst_link", link, 0);
    wait_clk(2000);
    check_eq("midrst_hold_valid", vq.size(), 0);
    check_eq("midrst_hold_ferr", fe_cnt, 0);
    rx = 1'b1;
    wait_clk(50);
    send_frame(8'hC6, 100, 1'b1);
    wait_clk(100);
    check_one("after_midrst", 8'hC6);

    // baud tolerance at -3% and +3%, and link width
    wait_clk(3200);
    clear_obs();
    link_hi = 0;
    link_rise = -1;
    send_frame(8'h12, 97, 1'b1);
    wait_clk(3200);
    check_one("fast_baud", 8'h12);
    check_eq("link_width", link_hi, 3000);
    if (cq.size() >= 1) check_eq("link_rise", link_rise - cq[0], 1);
    clear_obs();
    send_frame(8'hE7, 103, 1'b1);
    wait_clk(100);
    check_one("slow_baud", 8'hE7);

    // retrigger: second byte starts 1500 clocks after the first valid
    wait_clk(3200);
    clear_obs();
    link_hi = 0;
    link_last = -1;
    send_frame(8'h12, 97, 1'b1);
    wait_clk(2453 - 970);
    send_frame(8'h34, 100, 1'b1);
    wait_clk(3200);
    check_eq("retrig_count", vq.size(), 2);
    if (vq.size() == 2) begin
      check_eq("retrig_data1", vq[1], 8'h34);
      check_eq("retrig_gap", cq[1] - cq[0], 2453);
      check_eq("retrig_link_end", link_last - cq[1], 3000);
      check_eq("retrig_link_width", link_hi, 2453 + 3000);
    end

    check_eq("valid_ferr_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
